// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter (and the future receiver):
//   - tx_state_e : transmitter FSM states
//   - LINE_IDLE / START_LVL : serial line levels
//   - legal parameter ranges checked at elaboration time
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/baud_tick_detect.sv
// -----------------------------------------------------------------------------
// baud_tick_detect
// Rising-edge detector for the baud square wave. The baud clock comes from the
// same clock domain, so it is treated as plain synchronous data (no
// synchronizer). The previous-value register resets high, matching the baud
// generator's reset level, so no spurious tick appears when reset releases.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  asynchronous active-high reset
//   baud_i  in  baud square wave
//   tick_o  out one-cycle pulse in the cycle where baud_i is high after being low
// -----------------------------------------------------------------------------
module baud_tick_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic baud_i,
    output logic tick_o
);

    logic baud_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_prev_q <= 1'b1;
        end else begin
            baud_prev_q <= baud_i;
        end
    end

    assign tick_o = baud_i & ~baud_prev_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Asynchronous-serial transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits. Every bit boundary is a rising edge of baud_clk_in.
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   PARITY_EN  1 inserts a parity bit after the data
//   PARITY_ODD 0 even parity, 1 odd parity
//   STOP_BITS  stop bits per frame (1 or 2)
// Ports:
//   high_clk_in  in  system clock
//   reset        in  asynchronous active-high reset
//   baud_clk_in  in  baud square wave, one period per bit
//   tx_data      in  byte to send, sampled on accept only
//   tx_valid     in  upstream has data
//   tx_ready     out block can accept (only in IDLE)
//   tx_out       out serial line, idles high
//   tx_done      out one-cycle pulse when the last stop bit completes
//   state_dbg_o  out current FSM state (tx_state_e encoding)
//
// Handshake: a byte is accepted in any cycle where tx_valid and tx_ready are
// both high at the clock edge; tx_data is captured in that same edge and the
// upstream may change it freely afterwards.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 high_clk_in,
    input  logic                 reset,
    input  logic                 baud_clk_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_done,
    output logic [2:0]           state_dbg_o
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be within 5..8");
    end

    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);
    localparam logic       PAR_EN    = (PARITY_EN != 0);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_out_q, tx_out_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tick;

    baud_tick_detect u_tick (
        .clk_i  (high_clk_in),
        .rst_i  (reset),
        .baud_i (baud_clk_in),
        .tick_o (tick)
    );

    always_ff @(posedge high_clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= LINE_IDLE;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Each tick moves to the next state and registers the line level of the
    // state being entered, so the level changes on the edge after the tick.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick arriving together with the accept is deliberately
                // ignored; the start bit waits for the next tick.
                if (tx_valid && tx_ready_q) begin
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ PAR_ODD;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (tick) begin
                    state_d  = START;
                    tx_out_d = START_LVL;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_out_d  = shift_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        // shift_q[0] is on the line now; bit 1 goes out next.
                        shift_d   = shift_q >> 1;
                        tx_out_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (PAR_EN) begin
                        state_d  = PARITY;
                        tx_out_d = parity_q;
                    end else begin
                        state_d    = STOP;
                        tx_out_d   = LINE_IDLE;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    tx_out_d   = LINE_IDLE;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q != LAST_STOP) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = LINE_IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
    end

    assign tx_ready    = tx_ready_q;
    assign tx_out      = tx_out_q;
    assign tx_done     = tx_done_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Five transmitter configurations share one clock, reset and baud generator
// (HIGH_CLK=16, BAUD_CLK=1 -> DIVISOR=7, bit period 16 clocks):
//   0: 8N1   1: 8E1   2: 8O1   3: 8N2   4: 5 data, odd parity, 2 stop
// The reference model describes a frame as a list of bit levels; the line
// advances one list entry per baud rising edge, starting at the first edge
// strictly after the accept.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int N_INST = 5;

    function automatic int cfg_db(input int k);
        return (k == 4) ? 5 : 8;
    endfunction
    function automatic int cfg_pe(input int k);
        return (k == 1 || k == 2 || k == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_po(input int k);
        return (k == 2 || k == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int k);
        return (k >= 3) ? 2 : 1;
    endfunction

    // ---------------- clock / reset / baud generator ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud;
    logic       baud_rose;     // baud went 0->1 at the last edge: tick at the next edge
    logic       baud_en = 1'b1;
    logic [2:0] baud_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            baud      <= 1'b1;
            baud_cnt  <= 3'd0;
            baud_rose <= 1'b0;
        end else if (baud_en) begin
            if (baud_cnt == 3'd7) begin
                baud      <= ~baud;
                baud_cnt  <= 3'd0;
                baud_rose <= ~baud;
            end else begin
                baud_cnt  <= baud_cnt + 3'd1;
                baud_rose <= 1'b0;
            end
        end else begin
            baud_rose <= 1'b0;
        end
    end

    // ---------------- DUTs ----------------
    logic [N_INST-1:0] tx_valid_r = '0;
    logic [7:0]        tx_data_r [N_INST];
    logic [N_INST-1:0] tx_ready_w, tx_out_w, tx_done_w;
    logic [2:0]        state_w [N_INST];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        uart_tx #(
            .DATA_BITS  (cfg_db(g)),
            .PARITY_EN  (cfg_pe(g)),
            .PARITY_ODD (cfg_po(g)),
            .STOP_BITS  (cfg_sb(g))
        ) u_dut (
            .high_clk_in (clk),
            .reset       (reset),
            .baud_clk_in (baud),
            .tx_data     (tx_data_r[g][cfg_db(g)-1:0]),
            .tx_valid    (tx_valid_r[g]),
            .tx_ready    (tx_ready_w[g]),
            .tx_out      (tx_out_w[g]),
            .tx_done     (tx_done_w[g]),
            .state_dbg_o (state_w[g])
        );
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0] inst;
        logic [7:0] data;
        int         acc;   // sample index of the accept edge
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;

    bit          m_active   [N_INST];
    bit          m_done_exp [N_INST];
    int          m_bidx     [N_INST];
    int          m_n        [N_INST];
    logic [15:0] m_bits     [N_INST];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame as a list of line levels: start, data LSB first, parity, stops.
    function automatic void build_frame(input int k, input logic [7:0] d,
                                        output logic [15:0] bits, output int n);
        logic par;
        bits    = '1;
        bits[0] = 1'b0;
        n       = 1;
        par     = 1'b0;
        for (int i = 0; i < cfg_db(k); i++) begin
            bits[n] = d[i];
            par     = par ^ d[i];
            n++;
        end
        if (cfg_pe(k) != 0) begin
            bits[n] = (cfg_po(k) != 0) ? ~par : par;
            n++;
        end
        n = n + cfg_sb(k);
    endfunction

    function automatic int find_exp(input int k);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].inst == 3'(k)) return i;
        end
        return -1;
    endfunction

    task automatic mon_step(input int k, input bit tick);
        int idx;
        bit pending;
        if (m_active[k]) begin
            check("line_bit", tx_out_w[k], m_bits[k][m_bidx[k]]);
            check("ready_busy", tx_ready_w[k], 0);
            check("done_busy", tx_done_w[k], 0);
            if (tick) begin
                m_bidx[k]++;
                if (m_bidx[k] == m_n[k]) begin
                    m_active[k]   = 1'b0;
                    m_done_exp[k] = 1'b1;
                end
            end
        end else begin
            idx     = find_exp(k);
            pending = (idx >= 0) && (exp_q[idx].acc < ncyc);
            check("line_idle", tx_out_w[k], 1);
            if (m_done_exp[k]) begin
                check("done_pulse", tx_done_w[k], 1);
                check("ready_at_done", tx_ready_w[k], 1);
                m_done_exp[k] = 1'b0;
            end else begin
                check("no_done", tx_done_w[k], 0);
                check("ready_idle", tx_ready_w[k], pending ? 0 : 1);
            end
            if (pending && tick) begin
                build_frame(k, exp_q[idx].data, m_bits[k], m_n[k]);
                m_active[k] = 1'b1;
                m_bidx[k]   = 0;
                exp_q.delete(idx);
            end
        end
    endtask

    // Monitor and accept observer; inputs change at posedge+1, so every value
    // read here is stable.
    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            exp_q.delete();
            for (int k = 0; k < N_INST; k++) begin
                m_active[k]   = 1'b0;
                m_done_exp[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < N_INST; k++) mon_step(k, baud_rose);
            for (int k = 0; k < N_INST; k++) begin
                if (tx_valid_r[k] && tx_ready_w[k]) begin
                    exp_q.push_back('{inst: 3'(k), data: tx_data_r[k], acc: ncyc});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input int k);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(tx_valid_r[k] && tx_ready_w[k]) && t < 2000);
        check("accept_timeout", (t >= 2000) ? 1 : 0, 0);
    endtask

    // Sends cnt frames back to back with tx_valid held; data changes right
    // after each accept so a late change to tx_data is always exercised.
    task automatic send_burst(input int k, input int cnt, input logic [7:0] d0, input logic [7:0] d1);
        @(posedge clk); #1;
        tx_data_r[k]  = d0;
        tx_valid_r[k] = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            wait_accept(k);
            @(posedge clk); #1;
            if (i == cnt - 1) begin
                tx_valid_r[k] = 1'b0;
                tx_data_r[k]  = 8'($urandom);
            end else if (i == 0) begin
                tx_data_r[k] = d1;
            end else begin
                tx_data_r[k] = 8'($urandom);
            end
        end
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while ((exp_q.size() != 0 || m_active[k] || m_done_exp[k] || tx_valid_r[k]) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", (t >= 5000) ? 1 : 0, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_line(input int k, input logic lvl, output bit ok);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (tx_out_w[k] !== lvl && t < 400);
        ok = (t < 400);
    endtask

    // Clocks from the first start-bit sample to the tx_done pulse.
    task automatic measure_frame(input int k, input int nbits);
        int  cnt = 0;
        bit  ok;
        wait_line(k, 1'b0, ok);
        check("frame_start_timeout", ok ? 0 : 1, 0);
        do begin
            @(negedge clk);
            cnt++;
        end while (!tx_done_w[k] && cnt < 400);
        check("frame_length", cnt, nbits * 16);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  cnt;
        bit  ok;
        int  t;
        logic       lvl;
        logic [2:0] st;

        for (int k = 0; k < N_INST; k++) tx_data_r[k] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_INST; k++) begin
            check("reset_tx_out", tx_out_w[k], 1);
            check("reset_tx_ready", tx_ready_w[k], 1);
            check("reset_tx_done", tx_done_w[k], 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 single frame
        fork
            send_burst(0, 1, 8'hA5, 8'h00);
            measure_frame(0, 10);
        join
        wait_idle(0);

        // even parity 0xA5 -> parity 0, odd parity 0x01 -> parity 0
        fork
            send_burst(1, 1, 8'hA5, 8'h00);
            measure_frame(1, 11);
        join
        wait_idle(1);
        fork
            send_burst(2, 1, 8'h01, 8'h00);
            measure_frame(2, 11);
        join
        wait_idle(2);

        // two stop bits, back to back 0x00 then 0xFF: 32 stop + 16 idle high clocks
        fork
            send_burst(3, 2, 8'h00, 8'hFF);
            begin
                wait_line(3, 1'b0, ok);
                check("b2b_start_timeout", ok ? 0 : 1, 0);
                wait_line(3, 1'b1, ok);
                check("b2b_stop_timeout", ok ? 0 : 1, 0);
                cnt = 1;
                t   = 0;
                while (t < 400) begin
                    @(negedge clk);
                    t++;
                    if (tx_out_w[3] !== 1'b1) break;
                    cnt++;
                end
                check("b2b_gap_high_clocks", cnt, 48);
            end
        join
        wait_idle(3);

        // 5-bit odd parity 2 stop
        send_burst(4, 3, 8'h15, 8'h0A);
        wait_idle(4);

        // accept coincident with a tick: start waits a full bit period
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (baud_rose !== 1'b1 && t < 40);
        check("tick_align_timeout", (t >= 40) ? 1 : 0, 0);
        tx_data_r[0]  = 8'h3C;
        tx_valid_r[0] = 1'b1;
        @(negedge clk);
        check("tick_accept_ready", tx_ready_w[0], 1);
        cnt = 1;
        @(posedge clk); #1;
        tx_valid_r[0] = 1'b0;
        tx_data_r[0]  = 8'hC3;
        t = 0;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (tx_out_w[0] !== 1'b1) break;
            cnt++;
        end
        check("tick_accept_latency", cnt, 17);
        repeat (40) @(posedge clk);
        #1 tx_data_r[0] = 8'hFF;
        wait_idle(0);

        // reset in the middle of data bit 3 of 0x55
        send_burst(0, 1, 8'h55, 8'h00);
        t = 0;
        while (!(m_active[0] && m_bidx[0] == 4) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reset_point_timeout", (t >= 1000) ? 1 : 0, 0);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset_tx_out", tx_out_w[0], 1);
        check("midreset_tx_ready", tx_ready_w[0], 1);
        check("midreset_tx_done", tx_done_w[0], 0);
        repeat (2) @(negedge clk);
        check("midreset_done_hold", tx_done_w[0], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        fork
            send_burst(0, 1, 8'h96, 8'h00);
            measure_frame(0, 10);
        join
        wait_idle(0);

        // baud generator stalled during data
        send_burst(0, 1, 8'($urandom), 8'h00);
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(m_active[0] && m_bidx[0] == 3 && baud_rose == 1'b0) && t < 1000);
        check("stall_point_timeout", (t >= 1000) ? 1 : 0, 0);
        baud_en = 1'b0;
        lvl = tx_out_w[0];
        st  = state_w[0];
        repeat (100) @(negedge clk);
        check("stall_line_held", tx_out_w[0], lvl);
        check("stall_state_held", state_w[0], st);
        @(posedge clk); #1;
        baud_en = 1'b1;
        wait_idle(0);

        // random traffic over all configurations
        for (int it = 0; it < 25; it++) begin
            int k;
            k = $urandom_range(0, N_INST - 1);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            send_burst(k, $urandom_range(1, 3), 8'($urandom), 8'($urandom));
            wait_idle(k);
        end

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the square-wave baud clock from the baud generator and shifts out asynchronous-serial frames: start bit, LSB-first data, optional parity, one or two stop bits. It sits directly downstream of the baud generator. Both run on the same high-speed clock, and the baud clock is treated as a synchronous data signal whose rising edge marks each bit boundary. Upstream logic hands bytes in over a valid/ready handshake, and `tx_out` drives the board's serial pin.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `high_clk_in`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_clk_in`  in  1  baud square wave from the baud generator; one full period equals one bit time.
- `tx_data`  in  DATA_BITS  byte to send; sampled only on accept.
- `tx_valid`  in  1  upstream has data.
- `tx_ready`  out  1  block can accept; high only in IDLE.
- `tx_out`  out  1  serial line; idles high.
- `tx_done`  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- Tick detect: `baud_prev` is registered every cycle. `tick = baud_clk_in & ~baud_prev`. No synchronizer, because the source is same-domain.
- Accept: occurs in a cycle with `tx_valid && tx_ready`. `tx_data` is latched into a shift register, parity is precomputed (XOR of data, inverted if `PARITY_ODD`), and the FSM moves to ARMED.
- FSM advances only on `tick`. On each tick it drives the `tx_out` value of the state it enters.
  - IDLE → ARMED: on accept; ticks are ignored in IDLE.
  - ARMED → START: on tick; `tx_out`=0.
  - START → DATA: on tick; `tx_out`=bit0, `bit_cnt`=0.
  - DATA stays in DATA on tick while `bit_cnt` < DATA_BITS-1: shift, `tx_out`=next bit, `bit_cnt`++.
  - DATA → PARITY (if `PARITY_EN`) or STOP: on tick at the last bit. `tx_out` is the parity bit or 1 respectively.
  - PARITY → STOP: on tick; `tx_out`=1, `stop_cnt`=0.
  - STOP stays in STOP on tick while `stop_cnt` < STOP_BITS-1: `stop_cnt`++.
  - STOP → IDLE: on the final stop tick; `tx_done`=1 for that cycle.
- `tx_ready` is registered; it is 1 exactly when the next state is IDLE.
- Baud clock stopped (baud generator disabled): the FSM holds its state and `tx_out` holds its level indefinitely.
- Accept and tick in the same cycle: the tick is consumed as an IDLE tick. Start begins at the following tick.
- `tx_data` changing after accept has no effect on the frame in flight.
- Bit counter width: 3 bits. Stop counter: 1 bit.

## Timing
- Reset values: `tx_out`=1, `tx_ready`=1, `tx_done`=0, state=IDLE, `baud_prev`=1. The baud generator also resets its output high.
- Reset mid-frame: the line returns high immediately (asynchronous). The in-flight frame is aborted and not resumed.
- Latency: the start bit's falling edge appears on the clock after the first tick strictly later than the accept cycle. This is between 1 and P clocks after accept, where P is the baud period in clocks.
- Every bit, including start, parity and stop, lasts exactly P clocks.
- `tx_done` asserts on the same clock edge as the FSM's STOP → IDLE transition, coincident with `tx_ready` rising.
- Back-to-back with `tx_valid` held high:
  - The next accept happens 1 clock after `tx_done`.
  - That start bit therefore begins one bit time after the stop bit ends, giving exactly one extra idle bit between frames.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × P clocks.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, ARMED, START, DATA, PARITY, STOP);
  - the line levels `LINE_IDLE`=1 and `START_LVL`=0;
  - the legal-range bounds used by parameter checks.
- One natural sub-module, `baud_tick_detect`: the rising-edge detector on `baud_clk_in`. It is reusable by the future receiver.
- Elaboration-time checks on `DATA_BITS` range and `STOP_BITS` ∈ {1,2}.

## Test plan
- Bench uses a baud generator with HIGH_CLK=16 and BAUD_CLK=1, giving DIVISOR=7 and P=16.
- Single frame, 8N1: send 0xA5. Expect `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks, one `tx_done` pulse, and `tx_ready` low throughout.
- Parity: with PARITY_EN=1, even parity, send 0xA5; expect parity bit 0. With PARITY_ODD=1, send 0x01; expect parity bit 0. Both frames are 11 bits.
- Two stop bits with back-to-back frames: STOP_BITS=2, `tx_valid` held high with 0x00 then 0xFF.
  - Expect 32 high clocks of stop, then 16 idle clocks, then a start bit.
  - Expect the second frame's data to be all 1s.
- Handshake edges: assert `tx_valid` on the same cycle as a tick; the start must wait for the next tick. Change `tx_data` mid-frame; the frame must be unchanged.
- Reset mid-DATA: assert `reset` at bit 3 of 0x55. Expect `tx_out`=1 and `tx_ready`=1 immediately, no `tx_done`, and a clean new frame afterwards.
- Stall: disable the baud generator during DATA for 100 clocks. Expect `tx_out` held and the state unchanged; the frame completes correctly after re-enable.
